// File: rtl/pattern_scan_ctrl.sv
// Snoop-path pattern scan controller: accepts cache lines, sequences the external
// matcher, tracks patterns that continue into the next sequential line, reports hits.
//
// state | meaning
// IDLE  | ready for a line; o_line_ready high
// ARM   | operands driven, trigger low (matcher cleared)
// FIRE  | trigger raised, timeout timer loaded
// WAIT  | trigger held; wait for op_end or timer terminal count
// EVAL  | trigger low; return to IDLE or rescan the same line fresh
module pattern_scan_ctrl #(
  parameter int CL_SIZE    = 64,
  parameter int ADDR_WIDTH = 44,
  parameter int TIMEOUT    = 15
) (
  input  logic                    ace_aclk,
  input  logic                    ace_aresetn,
  input  logic                    i_enable,
  input  logic [CL_SIZE*8-1:0]    i_pattern,
  input  logic [4:0]              i_pattern_size,
  input  logic                    i_line_valid,
  output logic                    o_line_ready,
  input  logic [CL_SIZE*8-1:0]    i_line_data,
  input  logic [ADDR_WIDTH-1:0]   i_line_addr,
  output logic [CL_SIZE*8-1:0]    o_pattern,
  output logic [4:0]              o_pattern_size,
  output logic [CL_SIZE*8-1:0]    o_cache_line,
  output logic                    o_trigger,
  input  logic                    i_full_match,
  input  logic                    i_partial_match,
  input  logic [3:0]              i_match_offset,
  input  logic                    i_op_end,
  output logic                    o_hit,
  output logic [ADDR_WIDTH-1:0]   o_hit_addr,
  output logic [3:0]              o_hit_offset,
  output logic                    o_hit_span,
  output logic [31:0]             o_hit_count,
  output logic                    o_err,
  output logic                    o_busy
);

  localparam int LW = CL_SIZE * 8;
  localparam int NW = CL_SIZE / 4;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, WAIT, EVAL} state_t;

  state_t                state;
  logic [LW-1:0]         pat_q;
  logic [4:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  scan_cont;
  logic                  rescan;
  logic [TW-1:0]         timer;

  logic                  cont_pending;
  logic [ADDR_WIDTH-1:0] cont_addr;
  logic [3:0]            cont_off;
  logic [4:0]            cont_size;
  logic [LW-1:0]         cont_pat;

  logic                  size_ok;
  logic                  seq_line;
  logic [ADDR_WIDTH-1:0] cont_next;
  logic [4:0]            match_m;
  logic [LW-1:0]         pat_shift;

  logic                  hit_now;
  logic [ADDR_WIDTH-1:0] hit_addr_n;
  logic [3:0]            hit_off_n;
  logic                  hit_span_n;
  logic                  store_cont;
  logic                  need_rescan;

  assign size_ok   = (i_pattern_size != 5'd0) && (i_pattern_size <= 5'(NW));
  assign cont_next = cont_addr + ADDR_WIDTH'(CL_SIZE);
  assign seq_line  = cont_pending && (i_line_addr == cont_next);
  // m = words matched at the tail of the line; leftover pattern drops those words
  assign match_m   = 5'(NW) - {1'b0, i_match_offset};
  assign pat_shift = o_pattern >> {match_m, 5'd0};

  always_comb begin
    hit_now     = 1'b0;
    hit_addr_n  = addr_q;
    hit_off_n   = 4'd0;
    hit_span_n  = 1'b0;
    store_cont  = 1'b0;
    need_rescan = 1'b0;
    if (state == WAIT && i_op_end) begin
      if (scan_cont) begin
        if (i_full_match) begin
          hit_now    = 1'b1;
          hit_addr_n = cont_addr;
          hit_off_n  = cont_off;
          hit_span_n = 1'b1;
        end else begin
          need_rescan = 1'b1;
        end
      end else if (i_full_match) begin
        hit_now = 1'b1;
      end else if (i_partial_match) begin
        if (match_m >= o_pattern_size) begin
          hit_now   = 1'b1;
          hit_off_n = i_match_offset;
        end else begin
          store_cont = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ace_aclk) begin
    if (!ace_aresetn) begin
      state          <= IDLE;
      pat_q          <= '0;
      size_q         <= '0;
      addr_q         <= '0;
      scan_cont      <= 1'b0;
      rescan         <= 1'b0;
      timer          <= '0;
      cont_pending   <= 1'b0;
      cont_addr      <= '0;
      cont_off       <= '0;
      cont_size      <= '0;
      cont_pat       <= '0;
      o_line_ready   <= 1'b0;
      o_pattern      <= '0;
      o_pattern_size <= '0;
      o_cache_line   <= '0;
      o_trigger      <= 1'b0;
      o_hit          <= 1'b0;
      o_hit_addr     <= '0;
      o_hit_offset   <= '0;
      o_hit_span     <= 1'b0;
      o_hit_count    <= '0;
      o_err          <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_hit <= hit_now;
      if (hit_now) begin
        o_hit_addr   <= hit_addr_n;
        o_hit_offset <= hit_off_n;
        o_hit_span   <= hit_span_n;
        if (o_hit_count != '1) o_hit_count <= o_hit_count + 32'd1;
      end

      case (state)
        IDLE: begin
          o_line_ready <= 1'b1;
          if (i_line_valid && o_line_ready) begin
            if (i_enable && size_ok) begin
              state        <= ARM;
              o_line_ready <= 1'b0;
              o_busy       <= 1'b1;
              o_cache_line <= i_line_data;
              addr_q       <= i_line_addr;
              pat_q        <= i_pattern;
              size_q       <= i_pattern_size;
              if (seq_line) begin
                scan_cont      <= 1'b1;
                o_pattern      <= cont_pat;
                o_pattern_size <= cont_size;
              end else begin
                scan_cont      <= 1'b0;
                cont_pending   <= 1'b0;
                o_pattern      <= i_pattern;
                o_pattern_size <= i_pattern_size;
              end
            end else begin
              cont_pending <= 1'b0;
            end
          end
        end

        ARM: begin
          o_trigger <= 1'b1;
          state     <= FIRE;
        end

        FIRE: begin
          timer <= TW'(TIMEOUT);
          state <= WAIT;
        end

        WAIT: begin
          if (i_op_end) begin
            state     <= EVAL;
            o_trigger <= 1'b0;
            rescan    <= need_rescan;
            if (scan_cont) cont_pending <= 1'b0;
            if (store_cont) begin
              cont_pending <= 1'b1;
              cont_addr    <= addr_q;
              cont_off     <= i_match_offset;
              cont_size    <= o_pattern_size - match_m;
              cont_pat     <= pat_shift;
            end
          end else if (timer == TW'(1)) begin
            state        <= IDLE;
            o_trigger    <= 1'b0;
            o_err        <= 1'b1;
            o_busy       <= 1'b0;
            o_line_ready <= 1'b1;
            cont_pending <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        EVAL: begin
          if (rescan) begin
            state          <= ARM;
            rescan         <= 1'b0;
            scan_cont      <= 1'b0;
            o_pattern      <= pat_q;
            o_pattern_size <= size_q;
          end else begin
            state        <= IDLE;
            o_busy       <= 1'b0;
            o_line_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: behavioural matcher stub, table of line vectors,
// and a hit scoreboard that also checks accept-to-hit latency.
module tb_pattern_scan_ctrl;

  localparam int AW = 44;

  logic            ace_aclk = 1'b0;
  logic            ace_aresetn = 1'b0;
  logic            i_enable = 1'b0;
  logic [511:0]    i_pattern = '0;
  logic [4:0]      i_pattern_size = '0;
  logic            i_line_valid = 1'b0;
  logic            o_line_ready;
  logic [511:0]    i_line_data = '0;
  logic [AW-1:0]   i_line_addr = '0;
  logic [511:0]    o_pattern;
  logic [4:0]      o_pattern_size;
  logic [511:0]    o_cache_line;
  logic            o_trigger;
  logic            i_full_match = 1'b0;
  logic            i_partial_match = 1'b0;
  logic [3:0]      i_match_offset = '0;
  logic            i_op_end = 1'b0;
  logic            o_hit;
  logic [AW-1:0]   o_hit_addr;
  logic [3:0]      o_hit_offset;
  logic            o_hit_span;
  logic [31:0]     o_hit_count;
  logic            o_err;
  logic            o_busy;

  always #5 ace_aclk = ~ace_aclk;

  pattern_scan_ctrl #(.CL_SIZE(64), .ADDR_WIDTH(AW), .TIMEOUT(15)) dut (
    .ace_aclk(ace_aclk), .ace_aresetn(ace_aresetn), .i_enable(i_enable),
    .i_pattern(i_pattern), .i_pattern_size(i_pattern_size),
    .i_line_valid(i_line_valid), .o_line_ready(o_line_ready),
    .i_line_data(i_line_data), .i_line_addr(i_line_addr),
    .o_pattern(o_pattern), .o_pattern_size(o_pattern_size),
    .o_cache_line(o_cache_line), .o_trigger(o_trigger),
    .i_full_match(i_full_match), .i_partial_match(i_partial_match),
    .i_match_offset(i_match_offset), .i_op_end(i_op_end),
    .o_hit(o_hit), .o_hit_addr(o_hit_addr), .o_hit_offset(o_hit_offset),
    .o_hit_span(o_hit_span), .o_hit_count(o_hit_count), .o_err(o_err),
    .o_busy(o_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int trig_rises = 0;
  int trig_hi = 0;
  logic trig_prev = 1'b0;
  int exp_count = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [511:0]  line;
    logic [511:0]  pat;
    logic [4:0]    size;
    logic          en;
    logic          hit;
    logic [AW-1:0] haddr;
    logic [3:0]    hoff;
    logic          hspan;
    int            lat;
    int            scans;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [3:0]    o;
    logic          s;
    int            lat;
    int            acc;
  } exp_t;

  vec_t tv[16];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int i);
    return 32'hC0DE0010 + 32'(i);
  endfunction

  // n consecutive pattern words starting at word src, placed at line word dst
  function automatic logic [511:0] wl(input int dst, input int src, input int n);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[(dst+i)*32 +: 32] = wd(src + i);
    return r;
  endfunction

  function automatic vec_t mkv(input logic [AW-1:0] addr, input logic [511:0] line,
                               input logic [511:0] pat, input logic [4:0] size,
                               input logic en, input logic hit, input logic [AW-1:0] haddr,
                               input logic [3:0] hoff, input logic hspan,
                               input int lat, input int scans);
    vec_t v;
    v.addr = addr; v.line = line; v.pat = pat; v.size = size; v.en = en;
    v.hit = hit; v.haddr = haddr; v.hoff = hoff; v.hspan = hspan;
    v.lat = lat; v.scans = scans;
    return v;
  endfunction

  // Matcher behaviour: full = pattern at word 0; partial = smallest k whose
  // line tail matches the pattern prefix (or the whole pattern if it fits).
  function automatic logic [5:0] match_fn(input logic [511:0] pat, input logic [4:0] sz,
                                          input logic [511:0] ln);
    logic ok;
    ok = 1'b1;
    for (int j = 0; j < 16; j++)
      if (j < int'(sz) && ln[j*32 +: 32] != pat[j*32 +: 32]) ok = 1'b0;
    if (ok) return {2'b10, 4'd0};
    for (int k = 1; k < 16; k++) begin
      ok = 1'b1;
      for (int j = 0; j < 16; j++)
        if (j < int'(sz) && j < 16 - k)
          if (ln[(k+j)*32 +: 32] != pat[j*32 +: 32]) ok = 1'b0;
      if (ok) return {2'b01, 4'(k)};
    end
    return 6'd0;
  endfunction

  logic trig_d = 1'b0;
  logic stub_hang = 1'b0;
  logic [5:0] mres;

  always @(posedge ace_aclk) begin
    cyc <= cyc + 1;
    trig_d <= o_trigger;
    if (o_trigger && !trig_d && !stub_hang) begin
      mres = match_fn(o_pattern, o_pattern_size, o_cache_line);
      i_full_match    <= mres[5];
      i_partial_match <= mres[4];
      i_match_offset  <= mres[3:0];
      i_op_end        <= 1'b1;
    end else begin
      i_full_match    <= 1'b0;
      i_partial_match <= 1'b0;
      i_match_offset  <= 4'd0;
      i_op_end        <= 1'b0;
    end
  end

  exp_t e;
  always @(negedge ace_aclk) begin
    if (o_trigger && !trig_prev) trig_rises++;
    if (o_trigger) trig_hi++;
    trig_prev = o_trigger;
    if (o_hit) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_hit: got addr %0h expected no hit", o_hit_addr);
      end else begin
        e = sb.pop_front();
        chk("hit_addr", 64'(o_hit_addr), 64'(e.a));
        chk("hit_offset", 64'(o_hit_offset), 64'(e.o));
        chk("hit_span", 64'(o_hit_span), 64'(e.s));
        chk("hit_latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!o_line_ready && w < 100) begin
      @(negedge ace_aclk);
      w++;
    end
    if (!o_line_ready) chk({tag, "_ready_timeout"}, 64'(o_line_ready), 64'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input logic exp_err);
    exp_t x;
    wait_ready({tag, "_pre"});
    i_line_addr    = v.addr;
    i_line_data    = v.line;
    i_pattern      = v.pat;
    i_pattern_size = v.size;
    i_enable       = v.en;
    i_line_valid   = 1'b1;
    trig_rises     = 0;
    trig_hi        = 0;
    if (v.hit) begin
      exp_count++;
      x.a = v.haddr; x.o = v.hoff; x.s = v.hspan; x.lat = v.lat; x.acc = cyc;
      sb.push_back(x);
    end
    @(negedge ace_aclk);
    i_line_valid   = 1'b0;
    i_pattern      = {16{32'hDEADBEEF}};
    i_pattern_size = 5'd1;
    i_enable       = 1'b0;
    i_line_data    = '1;
    i_line_addr    = '1;
    if (v.scans == 0) chk({tag, "_ready_held"}, 64'(o_line_ready), 64'd1);
    wait_ready(tag);
    chk({tag, "_pending_hits"}, 64'(sb.size()), 64'd0);
    chk({tag, "_count"}, 64'(o_hit_count), 64'(exp_count));
    chk({tag, "_scans"}, 64'(trig_rises), 64'(v.scans));
    chk({tag, "_err"}, 64'(o_err), 64'(exp_err));
  endtask

  logic [511:0] p4;

  initial begin
    p4 = wl(0, 0, 4);
    tv[0]  = mkv(44'h1000, wl(0, 0, 3), wl(0, 0, 3), 5'd3, 1'b1, 1'b1, 44'h1000, 4'd0, 1'b0, 4, 1);
    tv[1]  = mkv(44'h1000, wl(14, 0, 2), p4, 5'd4, 1'b1, 1'b0, '0, 4'd0, 1'b0, 0, 1);
    tv[2]  = mkv(44'h1040, wl(0, 2, 2), p4, 5'd4, 1'b1, 1'b1, 44'h1000, 4'd14, 1'b1, 4, 1);
    tv[3]  = mkv(44'h1000, wl(14, 0, 2), p4, 5'd4, 1'b1, 1'b0, '0, 4'd0, 1'b0, 0, 1);
    tv[4]  = mkv(44'h2000, wl(0, 0, 4), p4, 5'd4, 1'b1, 1'b1, 44'h2000, 4'd0, 1'b0, 4, 1);
    tv[5]  = mkv(44'h3000, wl(14, 0, 2), wl(0, 0, 2), 5'd2, 1'b1, 1'b1, 44'h3000, 4'd14, 1'b0, 4, 1);
    tv[6]  = mkv(44'h4000, wl(14, 0, 2), p4, 5'd4, 1'b1, 1'b0, '0, 4'd0, 1'b0, 0, 1);
    tv[7]  = mkv(44'h4040, wl(4, 0, 4), p4, 5'd4, 1'b1, 1'b1, 44'h4040, 4'd4, 1'b0, 8, 2);
    tv[8]  = mkv(44'h6000, wl(0, 0, 3), wl(0, 0, 3), 5'd3, 1'b0, 1'b0, '0, 4'd0, 1'b0, 0, 0);
    tv[9]  = mkv(44'h6000, wl(0, 0, 3), wl(0, 0, 3), 5'd0, 1'b1, 1'b0, '0, 4'd0, 1'b0, 0, 0);
    tv[10] = mkv(44'h6000, wl(0, 0, 3), wl(0, 0, 3), 5'd17, 1'b1, 1'b0, '0, 4'd0, 1'b0, 0, 0);
    tv[11] = mkv(44'h5000, wl(14, 0, 2), p4, 5'd4, 1'b1, 1'b0, '0, 4'd0, 1'b0, 0, 1);
    tv[12] = mkv(44'h5040, wl(0, 2, 2), p4, 5'd4, 1'b0, 1'b0, '0, 4'd0, 1'b0, 0, 0);
    tv[13] = mkv(44'h5040, wl(0, 2, 2), p4, 5'd4, 1'b1, 1'b0, '0, 4'd0, 1'b0, 0, 1);
    tv[14] = mkv(44'hFFF_FFFF_FFC0, wl(14, 0, 2), p4, 5'd4, 1'b1, 1'b0, '0, 4'd0, 1'b0, 0, 1);
    tv[15] = mkv(44'h0, wl(0, 2, 2), p4, 5'd4, 1'b1, 1'b1, 44'hFFF_FFFF_FFC0, 4'd14, 1'b1, 4, 1);

    repeat (3) @(negedge ace_aclk);
    chk("rst_ready", 64'(o_line_ready), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_trigger", 64'(o_trigger), 64'd0);
    chk("rst_count", 64'(o_hit_count), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    ace_aresetn = 1'b1;
    @(negedge ace_aclk);
    chk("ready_after_reset", 64'(o_line_ready), 64'd1);

    for (int i = 0; i < 16; i++) run_vec($sformatf("v%0d", i), tv[i], 1'b0);

    // matcher never answers: 1 FIRE + 15 WAIT cycles of trigger, then abort
    stub_hang = 1'b1;
    run_vec("timeout", mkv(44'h7000, wl(0, 0, 3), wl(0, 0, 3), 5'd3, 1'b1, 1'b0, '0, 4'd0, 1'b0, 0, 1), 1'b1);
    chk("timeout_trigger_cycles", 64'(trig_hi), 64'd16);
    chk("timeout_busy", 64'(o_busy), 64'd0);
    stub_hang = 1'b0;
    run_vec("after_timeout", mkv(44'h8000, wl(0, 0, 3), wl(0, 0, 3), 5'd3, 1'b1, 1'b1, 44'h8000, 4'd0, 1'b0, 4, 1), 1'b1);

    // reset while waiting on the matcher
    stub_hang = 1'b1;
    wait_ready("mid_rst_pre");
    i_line_addr = 44'h9000; i_line_data = wl(0, 0, 3); i_pattern = wl(0, 0, 3);
    i_pattern_size = 5'd3; i_enable = 1'b1; i_line_valid = 1'b1;
    @(negedge ace_aclk);
    i_line_valid = 1'b0;
    repeat (3) @(negedge ace_aclk);
    chk("mid_busy", 64'(o_busy), 64'd1);
    chk("mid_trigger", 64'(o_trigger), 64'd1);
    ace_aresetn = 1'b0;
    exp_count = 0;
    @(negedge ace_aclk);
    chk("mid_rst_ready", 64'(o_line_ready), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_trigger", 64'(o_trigger), 64'd0);
    chk("mid_rst_hit", 64'(o_hit), 64'd0);
    chk("mid_rst_count", 64'(o_hit_count), 64'd0);
    chk("mid_rst_err", 64'(o_err), 64'd0);
    chk("mid_rst_hit_addr", 64'(o_hit_addr), 64'd0);
    chk("mid_rst_operands", 64'(|{o_pattern, o_cache_line, o_pattern_size}), 64'd0);
    ace_aresetn = 1'b1;
    stub_hang = 1'b0;
    @(negedge ace_aclk);
    run_vec("post_rst", tv[0], 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Sequences the cache-line pattern matcher for the snoop data path.
- Accepts snooped cache lines over a valid/ready handshake and drives the matcher's operands and trigger.
- Tracks patterns that start mid-line and continue into the next sequential line.
- Reports hits with the line address and word offset, and keeps a hit counter and error status.

Parameters:
- CL_SIZE, 64, cache line size in bytes (16 words of 32 bits).
- ADDR_WIDTH, 44, snoop address width.
- TIMEOUT, 15, maximum cycles to wait for matcher op_end before aborting.

Ports:
- ace_aclk  in  1  clock.
- ace_aresetn  in  1  synchronous active-low reset.
- i_enable  in  1  scan enable; sampled at line accept.
- i_pattern  in  CL_SIZE*8  pattern, word 0 in bits [31:0].
- i_pattern_size  in  5  pattern length in words, valid range 1..16.
- i_line_valid  in  1  snooped line valid.
- o_line_ready  out  1  controller can accept a line.
- i_line_data  in  CL_SIZE*8  snooped line data.
- i_line_addr  in  ADDR_WIDTH  line-aligned address.
- o_pattern  out  CL_SIZE*8  matcher pattern operand.
- o_pattern_size  out  5  matcher size operand.
- o_cache_line  out  CL_SIZE*8  matcher line operand.
- o_trigger  out  1  matcher trigger; low clears the matcher, high starts an operation.
- i_full_match, i_partial_match  in  1 each  matcher results.
- i_match_offset  in  4  matcher word offset.
- i_op_end  in  1  matcher operation done.
- o_hit  out  1  one-cycle pulse on pattern found.
- o_hit_addr  out  ADDR_WIDTH  address of the line where the pattern starts.
- o_hit_offset  out  4  word offset of the pattern start.
- o_hit_span  out  1  the hit crossed into the next line.
- o_hit_count  out  32  saturating hit counter.
- o_err  out  1  sticky matcher-timeout flag.
- o_busy  out  1  not in IDLE.

Behaviour:
- Reset: all outputs 0, including o_line_ready; FSM goes to IDLE; continuation state cleared.
- o_line_ready = 1 only in IDLE, starting the cycle after reset deassertion.
- A line is accepted on i_line_valid && o_line_ready. At accept, the controller latches line, addr, pattern, size and enable.
  - Config changes after accept are ignored until the next accept.
- Accept with enable = 0 or size outside 1..16: line dropped, continuation cleared, FSM stays in IDLE.
- FSM states: IDLE, ARM, FIRE, WAIT, EVAL.
  - IDLE: accepted and enabled line -> ARM.
  - ARM: operands driven, o_trigger = 0 for exactly 1 cycle -> FIRE.
  - FIRE: o_trigger = 1 -> WAIT.
  - WAIT: o_trigger held 1; i_op_end = 1 -> EVAL.
  - WAIT: timer reaches TIMEOUT -> IDLE, o_err set, continuation cleared, no hit.
  - EVAL: o_trigger = 0; act on the result (below), then -> IDLE or ARM (rescan).
- Operands are held stable from ARM through EVAL.
- Minimum accept-to-hit latency with a single-cycle matcher: o_hit asserts 4 cycles after the accept cycle.
- Fresh scan (no continuation pending):
  - o_pattern = latched pattern, o_pattern_size = size.
  - full_match -> hit, offset 0, span 0.
  - partial_match with offset k, where m = 16 - k words matched:
    - if m >= size -> hit at offset k, span 0.
    - else store the pending continuation: start addr, k, remaining r = size - m, pattern shifted right by 32*m bits. No hit.
  - No match -> no action.
- Continuation scan: runs when a continuation is pending and the new line addr == stored addr + CL_SIZE. A modulo 2^ADDR_WIDTH wrap counts as sequential.
  - o_pattern = shifted pattern, o_pattern_size = r.
  - full_match -> hit with the stored addr/offset, span 1; continuation cleared.
  - Any other result -> continuation cleared, then a fresh scan of the same line (EVAL -> ARM, no new accept).
- Pending continuation but non-sequential line: continuation dropped, fresh scan only.
- o_hit_count increments on each o_hit and saturates at 0xFFFFFFFF. o_err clears only on reset.
- Hit outputs hold their last value between pulses.
- Reset mid-operation: aborts immediately, no hit reported.

Test Plan:
- Pattern = 3 words {A,B,C}, size 3; line words 0..2 = A,B,C, rest 0; addr 0x1000 -> o_hit with o_hit_addr 0x1000, offset 0, span 0, count 1, 4 cycles after accept.
- Size 4 {A,B,C,D}; line 0x1000 has A,B at words 14,15; line 0x1040 has C,D at words 0,1 -> no hit on the first line; on the second, o_hit with addr 0x1000, offset 14, span 1.
- Same first line, then next line at 0x2000 containing A,B,C,D at words 0..3 -> continuation dropped; fresh hit with addr 0x2000, offset 0, span 0.
- Size 2 {A,B}; line has A,B at words 14,15 -> hit at offset 14, span 0 (m = 2 >= size).
- Matcher stub never raises op_end -> after 15 WAIT cycles FSM returns to IDLE, o_err = 1, o_line_ready = 1, no hit.
- i_enable = 0, or size 0 or 17 -> line accepted with o_line_ready held at 1, no trigger pulse, no hit; reset asserted in WAIT -> all outputs 0 next cycle, count 0.
